// File: rtl/keypad_emulator_if.sv
// Scanner-side signal bundle of the keypad emulator: column drive in, row lines
// out, plus the press request handshake and status.
interface keypad_emulator_if;
  logic [3:0] columnas;
  logic [3:0] key_code;
  logic       press_valid;
  logic       press_ready;
  logic [3:0] filas;
  logic       busy;
  logic       done;
  logic       contact;

  modport master (
    output columnas, key_code, press_valid,
    input  press_ready, filas, busy, done, contact
  );

  modport slave (
    input  columnas, key_code, press_valid,
    output press_ready, filas, busy, done, contact
  );
endinterface

// File: rtl/keypad_emulator.sv
// Passive 4x4 matrix keypad model: replays one requested key press with
// pseudo-random contact bounce on press and release, driving the row lines.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 2700,
  parameter int unsigned HOLD_CYCLES   = 270000,
  parameter int unsigned BOUNCE_TOGGLE = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic         clk,
  input logic         reset,
  keypad_emulator_if.slave kp
);

  localparam int unsigned CNT_MAX = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned TW      = $clog2(BOUNCE_TOGGLE + 1);

  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] BOUNCE_LOAD = CW'((BOUNCE_CYCLES == 0) ? 0 : BOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TOGGLE_MASK = TW'(BOUNCE_TOGGLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HELD,
    BOUNCE_OUT,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] phase_cnt;
  logic [TW-1:0] tgl_cnt;
  logic [TW-1:0] tgl_reload;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [3:0]    code;
  logic          contact_q;
  logic          accept;
  logic          phase_end;
  logic          tgl_expire;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [3:0]    row_oh;
  logic [3:0]    col_oh;

  assign accept     = kp.press_valid && (state == IDLE);
  assign phase_end  = (phase_cnt == '0);
  assign tgl_expire = (tgl_cnt <= TW'(1));
  assign tgl_reload = (lfsr[TW-1:0] & TOGGLE_MASK) + TW'(1);
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept) state_nxt = (BOUNCE_CYCLES == 0) ? HELD : BOUNCE_IN;
      BOUNCE_IN:  if (phase_end) state_nxt = HELD;
      HELD:       if (phase_end) state_nxt = (BOUNCE_CYCLES == 0) ? DONE : BOUNCE_OUT;
      BOUNCE_OUT: if (phase_end) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    kp.press_ready = (state == IDLE);
    kp.busy        = (state != IDLE);
    kp.done        = (state == DONE);
  end

  // Phase counter holds cycles-remaining-minus-one; the toggle timer runs 1..BOUNCE_TOGGLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt <= '0;
      tgl_cnt   <= '0;
      lfsr      <= LFSR_SEED;
      code      <= '0;
      contact_q <= 1'b0;
    end else begin
      if (state != IDLE) lfsr <= {lfsr[14:0], lfsr_fb};
      case (state)
        IDLE: begin
          if (accept) begin
            code      <= kp.key_code;
            contact_q <= 1'b1;
            tgl_cnt   <= tgl_reload;
            phase_cnt <= (BOUNCE_CYCLES == 0) ? HOLD_LOAD : BOUNCE_LOAD;
          end
        end
        BOUNCE_IN: begin
          if (phase_end) begin
            contact_q <= 1'b1;
            phase_cnt <= HOLD_LOAD;
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
            if (tgl_expire) begin
              contact_q <= ~contact_q;
              tgl_cnt   <= tgl_reload;
            end else begin
              tgl_cnt <= tgl_cnt - TW'(1);
            end
          end
        end
        HELD: begin
          if (phase_end) begin
            if (BOUNCE_CYCLES == 0) begin
              contact_q <= 1'b0;
            end else begin
              tgl_cnt   <= tgl_reload;
              phase_cnt <= BOUNCE_LOAD;
            end
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
          end
        end
        BOUNCE_OUT: begin
          if (phase_end) begin
            contact_q <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
            if (tgl_expire) begin
              contact_q <= ~contact_q;
              tgl_cnt   <= tgl_reload;
            end else begin
              tgl_cnt <= tgl_cnt - TW'(1);
            end
          end
        end
        DONE:    contact_q <= 1'b0;
        default: contact_q <= 1'b0;
      endcase
    end
  end

  // Key map: code -> (row, column), matching the scanner's decode
  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    case (code)
      4'h1: begin row_idx = 2'd0; col_idx = 2'd0; end
      4'h2: begin row_idx = 2'd0; col_idx = 2'd1; end
      4'h3: begin row_idx = 2'd0; col_idx = 2'd2; end
      4'hA: begin row_idx = 2'd0; col_idx = 2'd3; end
      4'h4: begin row_idx = 2'd1; col_idx = 2'd0; end
      4'h5: begin row_idx = 2'd1; col_idx = 2'd1; end
      4'h6: begin row_idx = 2'd1; col_idx = 2'd2; end
      4'hB: begin row_idx = 2'd1; col_idx = 2'd3; end
      4'h7: begin row_idx = 2'd2; col_idx = 2'd0; end
      4'h8: begin row_idx = 2'd2; col_idx = 2'd1; end
      4'h9: begin row_idx = 2'd2; col_idx = 2'd2; end
      4'hC: begin row_idx = 2'd2; col_idx = 2'd3; end
      4'hD: begin row_idx = 2'd3; col_idx = 2'd0; end
      4'h0: begin row_idx = 2'd3; col_idx = 2'd1; end
      4'hE: begin row_idx = 2'd3; col_idx = 2'd2; end
      4'hF: begin row_idx = 2'd3; col_idx = 2'd3; end
      default: begin row_idx = 2'd0; col_idx = 2'd0; end
    endcase
    row_oh = 4'b1000 >> row_idx;
    col_oh = 4'b1000 >> col_idx;
  end

  // Electrical model: any overlapping active column connects the row
  always_comb begin
    kp.contact = contact_q;
    kp.filas   = (contact_q && ((kp.columnas & col_oh) != 4'b0000)) ? row_oh : 4'b0000;
  end

endmodule
